// File: rtl/mdu_seq_pkg.sv
// ============================================================================
// Module  : mdu_seq_pkg
// Brief   : Shared M-extension encodings, FSM states and helpers for mdu_seq.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_seq_pkg;

    localparam logic [6:0] c_mdu_func7 = 7'h01;

    localparam logic [2:0] c_mdu_mul    = 3'd0;
    localparam logic [2:0] c_mdu_mulh   = 3'd1;
    localparam logic [2:0] c_mdu_mulhsu = 3'd2;
    localparam logic [2:0] c_mdu_mulhu  = 3'd3;
    localparam logic [2:0] c_mdu_div    = 3'd4;
    localparam logic [2:0] c_mdu_divu   = 3'd5;
    localparam logic [2:0] c_mdu_rem    = 3'd6;
    localparam logic [2:0] c_mdu_remu   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } mdu_state_t;

    function automatic logic rs1_is_signed(input logic [2:0] func3);
        return (func3 == c_mdu_mulh) || (func3 == c_mdu_mulhsu) ||
               (func3 == c_mdu_div)  || (func3 == c_mdu_rem);
    endfunction

    function automatic logic rs2_is_signed(input logic [2:0] func3);
        return (func3 == c_mdu_mulh) || (func3 == c_mdu_div) ||
               (func3 == c_mdu_rem);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_seq_step.sv
// ============================================================================
// Module  : mdu_seq_step
// Brief   : One combinational iteration: shift-add multiply or restoring divide.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_seq_step #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    input  logic              is_div,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0]     w_sum;
    logic [2*XLEN-1:0] w_mul_next;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;
    logic              w_ge;
    logic [XLEN-1:0]   w_rem;
    logic [2*XLEN-1:0] w_div_next;

    // Multiply: acc = {partial high, remaining multiplier}; the carry out of
    // the add becomes the new top bit after the right shift.
    always_comb begin
        w_sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
        w_mul_next = {w_sum, acc[XLEN-1:1]};
    end

    // Divide: acc = {partial remainder, dividend bits / quotient bits}.
    always_comb begin
        w_shift    = acc[2*XLEN-1:XLEN-1];
        w_diff     = w_shift - {1'b0, operand};
        w_ge       = ~w_diff[XLEN];
        w_rem      = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
        w_div_next = {w_rem, acc[XLEN-2:0], w_ge};
    end

    assign acc_next = is_div ? w_div_next : w_mul_next;

endmodule

`default_nettype wire

// File: rtl/mdu_seq.sv
// ============================================================================
// Module  : mdu_seq
// Brief   : Iterative RV32M/RV64M multiply/divide sequencer with stall/flush.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            E_valid_i,
    input  logic [2:0]      E_func3_i,
    input  logic [XLEN-1:0] E_valA_i,
    input  logic [XLEN-1:0] E_valB_i,
    input  logic            E_flush_i,
    output logic            e_ready_o,
    output logic            e_stall_o,
    output logic            e_resp_valid_o,
    input  logic            e_resp_ready_i,
    output logic [XLEN-1:0] e_mdu_res_o
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  c_min  = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_t r_state, w_next;

    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_func3;
    logic              r_sign_a;
    logic              r_sign_b;
    logic [XLEN-1:0]   r_op;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_res;

    logic              w_accept;
    logic              w_sign_a;
    logic              w_sign_b;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_div_zero;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_spec_res;
    logic [2*XLEN-1:0] w_acc_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_res;

    // Operand conditioning at accept time
    always_comb begin
        w_sign_a   = rs1_is_signed(E_func3_i) & E_valA_i[XLEN-1];
        w_sign_b   = rs2_is_signed(E_func3_i) & E_valB_i[XLEN-1];
        w_abs_a    = w_sign_a ? (~E_valA_i + 1'b1) : E_valA_i;
        w_abs_b    = w_sign_b ? (~E_valB_i + 1'b1) : E_valB_i;
        w_div_zero = E_func3_i[2] & (E_valB_i == '0);
        w_ovf      = E_func3_i[2] & ~E_func3_i[0] &
                     (E_valA_i == c_min) & (E_valB_i == '1);
        w_special  = w_div_zero | w_ovf;
        if (w_div_zero)
            w_spec_res = E_func3_i[1] ? E_valA_i : '1;
        else
            w_spec_res = E_func3_i[1] ? '0 : c_min;
    end

    mdu_seq_step #(
        .XLEN (XLEN)
    ) u_step (
        .acc      (r_acc),
        .operand  (r_op),
        .is_div   (r_state == S_DIV),
        .acc_next (w_acc_next)
    );

    // Sign correction: quotient/product negate on sign mismatch, remainder
    // follows the dividend.
    always_comb begin
        w_prod    = (r_sign_a ^ r_sign_b) ? (~r_acc + 1'b1) : r_acc;
        w_quot    = (r_sign_a ^ r_sign_b) ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
        w_rem     = r_sign_a ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];
        w_fix_res = w_prod[XLEN-1:0];
        case (r_func3)
            c_mdu_mul:                         w_fix_res = w_prod[XLEN-1:0];
            c_mdu_mulh, c_mdu_mulhsu, c_mdu_mulhu: w_fix_res = w_prod[2*XLEN-1:XLEN];
            c_mdu_div, c_mdu_divu:             w_fix_res = w_quot;
            default:                           w_fix_res = w_rem;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        w_accept       = 1'b0;
        e_ready_o      = 1'b0;
        e_resp_valid_o = 1'b0;
        e_stall_o      = 1'b1;
        case (r_state)
            S_IDLE: begin
                e_ready_o = 1'b1;
                e_stall_o = 1'b0;
                w_accept  = E_valid_i & ~E_flush_i;
                if (w_accept) begin
                    if (w_special)
                        w_next = S_DONE;
                    else
                        w_next = E_func3_i[2] ? S_DIV : S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                if (r_cnt == c_last)
                    w_next = S_FIX;
            end
            S_FIX: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                e_resp_valid_o = 1'b1;
                e_stall_o      = ~e_resp_ready_i;
                if (e_resp_ready_i)
                    w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (E_flush_i)
            w_next = S_IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt    <= '0;
            r_func3  <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_op     <= '0;
            r_acc    <= '0;
            r_res    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt    <= '0;
                        r_func3  <= E_func3_i;
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        // Multiply iterates over rs2 with rs1 as addend;
                        // divide shifts rs1 through with rs2 as divisor.
                        r_op     <= E_func3_i[2] ? w_abs_b : w_abs_a;
                        r_acc    <= {{XLEN{1'b0}}, (E_func3_i[2] ? w_abs_a : w_abs_b)};
                        if (w_special)
                            r_res <= w_spec_res;
                    end
                end
                S_MUL, S_DIV: begin
                    r_acc <= w_acc_next;
                    r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_res <= w_fix_res;
                end
                default: begin
                end
            endcase
        end
    end

    assign e_mdu_res_o = r_res;

endmodule

`default_nettype wire

// File: tb/tb_mdu_seq.sv
// ============================================================================
// Module  : tb_mdu_seq
// Brief   : Directed, table-driven self-checking bench for mdu_seq.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [2:0]  func3 = '0;
    logic [31:0] val_a = '0;
    logic [31:0] val_b = '0;
    logic        flush = 1'b0;
    logic        resp_ready = 1'b1;
    logic        ready;
    logic        stall;
    logic        resp_valid;
    logic [31:0] res;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mdu_seq #(
        .XLEN (32)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .E_valid_i      (valid),
        .E_func3_i      (func3),
        .E_valA_i       (val_a),
        .E_valB_i       (val_b),
        .E_flush_i      (flush),
        .e_ready_o      (ready),
        .e_stall_o      (stall),
        .e_resp_valid_o (resp_valid),
        .e_resp_ready_i (resp_ready),
        .e_mdu_res_o    (res)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues one op (accepted on the next posedge); returns cycles until
    // resp_valid and whether stall behaved on every intervening cycle.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output int n, output logic stall_ok);
        @(negedge clk);
        valid = 1'b1; func3 = f; val_a = a; val_b = b;
        @(posedge clk);
        #1;
        valid = 1'b0; val_a = '0; val_b = '0;
        n = 1;
        stall_ok = 1'b1;
        while (!resp_valid && n < 100) begin
            if (stall !== 1'b1) stall_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int          n;
        logic        sok;
        vecs[0]  = '{3'd0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 34};
        vecs[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
        vecs[2]  = '{3'd2, 32'hFFFFFFFF, 32'd2,         32'hFFFFFFFF, 34};
        vecs[3]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 34};
        vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,         32'hFFFFFFFD, 34};
        vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,         32'hFFFFFFFF, 34};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,       34};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,        34};
        vecs[8]  = '{3'd4, 32'd5,         32'd0,         32'hFFFFFFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,         32'd0,         32'd5,        1};
        vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
        vecs[12] = '{3'd0, 32'h12345678, 32'h00000010, 32'h23456780, 34};
        vecs[13] = '{3'd1, 32'hFFFFFFF9, 32'd3,         32'hFFFFFFFF, 34};
        vecs[14] = '{3'd6, 32'd7,         32'hFFFFFFFE, 32'd1,        34};
        vecs[15] = '{3'd7, 32'hDEADBEEF, 32'd0,         32'hDEADBEEF, 1};

        #12;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_res", res, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].f3, vecs[i].a, vecs[i].b, n, sok);
            check($sformatf("v%0d_lat", i), n, vecs[i].lat);
            check($sformatf("v%0d_res", i), res, vecs[i].exp);
            check($sformatf("v%0d_stall_busy", i), {31'd0, sok}, 32'd1);
            check($sformatf("v%0d_stall_hs", i), {31'd0, stall}, 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_idle", i), {31'd0, ready}, 32'd1);
        end

        // Backpressure in DONE
        resp_ready = 1'b0;
        issue(3'd5, 32'd100, 32'd7, n, sok);
        check("bp_lat", n, 34);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("bp_valid", {31'd0, resp_valid}, 32'd1);
            check("bp_res", res, 32'd14);
            check("bp_stall", {31'd0, stall}, 32'd1);
        end
        resp_ready = 1'b1;
        #1;
        check("bp_release_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        check("bp_idle_ready", {31'd0, ready}, 32'd1);
        check("bp_idle_valid", {31'd0, resp_valid}, 32'd0);

        // Flush during DIV at T+10
        @(negedge clk);
        valid = 1'b1; func3 = 3'd4; val_a = 32'd1000; val_b = 32'd3;
        @(posedge clk);
        #1;
        valid = 1'b0;
        for (int k = 1; k < 10; k++) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("fl_ready", {31'd0, ready}, 32'd1);
        check("fl_stall", {31'd0, stall}, 32'd0);
        sok = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (resp_valid) sok = 1'b0;
        end
        check("fl_no_resp", {31'd0, sok}, 32'd1);

        // Flush in DONE beats a coincident handshake
        resp_ready = 1'b0;
        issue(3'd0, 32'd6, 32'd7, n, sok);
        check("fd_res", res, 32'd42);
        flush = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("fd_valid", {31'd0, resp_valid}, 32'd0);
        check("fd_ready", {31'd0, ready}, 32'd1);

        // Reset mid-MUL, then a following op
        @(negedge clk);
        valid = 1'b1; func3 = 3'd0; val_a = 32'd9; val_b = 32'd9;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mr_ready", {31'd0, ready}, 32'd1);
        check("mr_stall", {31'd0, stall}, 32'd0);
        check("mr_valid", {31'd0, resp_valid}, 32'd0);
        check("mr_res", res, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(3'd7, 32'd100, 32'd9, n, sok);
        check("mr_after_lat", n, 34);
        check("mr_after_res", res, 32'd1);
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
